// File: rtl/complex_div_iter.sv
// Sequential Q15 complex divider: res = (a+jb)/(c+jd).
// One operation in flight; the numerator and denominator products are formed
// in one cycle, then two restoring dividers produce 15 quotient bits (MSB first),
// and the saturated result is held until the downstream consumer takes it.
module complex_div_iter #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] x0_re,
    input  logic [DATA_WIDTH-1:0] x0_im,
    input  logic [DATA_WIDTH-1:0] x1_re,
    input  logic [DATA_WIDTH-1:0] x1_im,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] res_re,
    output logic [DATA_WIDTH-1:0] res_im,
    output logic                  div_by_zero
);

    // Only Q15 operands are supported; any other width is rejected at elaboration.
    if (DATA_WIDTH != 16) begin : gen_bad_width
        $error("complex_div_iter: DATA_WIDTH must be 16");
    end

    typedef enum logic [1:0] {
        IDLE,
        MULT,
        DIV,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    // Captured operands, held for the whole operation.
    logic signed [15:0] a_q;
    logic signed [15:0] b_q;
    logic signed [15:0] c_q;
    logic signed [15:0] d_q;

    // Divider state.
    logic [31:0] den_q;
    logic        dz_q;
    logic        ovf_re_q;
    logic        ovf_im_q;
    logic        neg_re_q;
    logic        neg_im_q;
    logic [31:0] rem_re_q;
    logic [31:0] rem_im_q;
    logic [13:0] q_re_q;
    logic [13:0] q_im_q;
    logic [3:0]  cnt;

    // Products and Q30 numerator/denominator terms.
    logic signed [31:0] prod_ac;
    logic signed [31:0] prod_bd;
    logic signed [31:0] prod_bc;
    logic signed [31:0] prod_ad;
    logic signed [31:0] prod_cc;
    logic signed [31:0] prod_dd;
    logic signed [32:0] num_re;
    logic signed [32:0] num_im;
    logic [32:0]        mag_re;
    logic [32:0]        mag_im;
    logic [31:0]        den;

    // One restoring-division step per component.
    logic [31:0] sh_re;
    logic [31:0] sh_im;
    logic        bit_re;
    logic        bit_im;
    logic [31:0] rem_re_nxt;
    logic [31:0] rem_im_nxt;
    logic [14:0] q_re_nxt;
    logic [14:0] q_im_nxt;

    assign in_ready = (state == IDLE);

    // Full-range products: every operand may be -32768, so c*c and d*d reach 2^30
    // and each numerator magnitude reaches 2^31; 33-bit signed sums cover that.
    assign prod_ac = 32'(a_q) * 32'(c_q);
    assign prod_bd = 32'(b_q) * 32'(d_q);
    assign prod_bc = 32'(b_q) * 32'(c_q);
    assign prod_ad = 32'(a_q) * 32'(d_q);
    assign prod_cc = 32'(c_q) * 32'(c_q);
    assign prod_dd = 32'(d_q) * 32'(d_q);
    assign num_re  = 33'(prod_ac) + 33'(prod_bd);
    assign num_im  = 33'(prod_bc) - 33'(prod_ad);
    assign mag_re  = num_re[32] ? 33'(-num_re) : 33'(num_re);
    assign mag_im  = num_im[32] ? 33'(-num_im) : 33'(num_im);
    assign den     = $unsigned(prod_cc) + $unsigned(prod_dd);

    // The doubled remainder can reach 2^32, so the bit shifted out of the top
    // forces a subtract; the 32-bit wrapped difference is then exact.
    assign sh_re      = {rem_re_q[30:0], 1'b0};
    assign sh_im      = {rem_im_q[30:0], 1'b0};
    assign bit_re     = rem_re_q[31] | (sh_re >= den_q);
    assign bit_im     = rem_im_q[31] | (sh_im >= den_q);
    assign rem_re_nxt = bit_re ? (sh_re - den_q) : sh_re;
    assign rem_im_nxt = bit_im ? (sh_im - den_q) : sh_im;
    assign q_re_nxt   = {q_re_q, bit_re};
    assign q_im_nxt   = {q_im_q, bit_im};

    // Final per-component result. With a zero denominator the numerator products
    // are all zero, so the saturation direction follows the numerator operand itself.
    function automatic logic [15:0] pick_result(
        input logic        dz,
        input logic [15:0] num_op,
        input logic        ovf,
        input logic        neg,
        input logic [14:0] q
    );
        logic [15:0] r;
        if (dz) begin
            if (num_op == 16'd0) r = 16'h0000;
            else if (num_op[15]) r = 16'h8000;
            else                 r = 16'h7FFF;
        end else if (ovf) begin
            r = neg ? 16'h8000 : 16'h7FFF;
        end else begin
            r = neg ? (16'd0 - {1'b0, q}) : {1'b0, q};
        end
        return r;
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: accept, multiply, iterate, then hold until consumed.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid)       state_nxt = MULT;
            MULT:                     state_nxt = DIV;
            DIV:  if (cnt == 4'd0)    state_nxt = DONE;
            DONE: if (out_ready)      state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, product setup, quotient iteration and result hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            d_q         <= '0;
            den_q       <= '0;
            dz_q        <= 1'b0;
            ovf_re_q    <= 1'b0;
            ovf_im_q    <= 1'b0;
            neg_re_q    <= 1'b0;
            neg_im_q    <= 1'b0;
            rem_re_q    <= '0;
            rem_im_q    <= '0;
            q_re_q      <= '0;
            q_im_q      <= '0;
            cnt         <= '0;
            out_valid   <= 1'b0;
            res_re      <= '0;
            res_im      <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q <= x0_re;
                        b_q <= x0_im;
                        c_q <= x1_re;
                        d_q <= x1_im;
                    end
                end
                MULT: begin
                    den_q    <= den;
                    dz_q     <= (den == 32'd0);
                    neg_re_q <= num_re[32];
                    neg_im_q <= num_im[32];
                    ovf_re_q <= (mag_re >= {1'b0, den});
                    ovf_im_q <= (mag_im >= {1'b0, den});
                    rem_re_q <= mag_re[31:0];
                    rem_im_q <= mag_im[31:0];
                    q_re_q   <= '0;
                    q_im_q   <= '0;
                    cnt      <= 4'd14;
                end
                DIV: begin
                    rem_re_q <= rem_re_nxt;
                    rem_im_q <= rem_im_nxt;
                    q_re_q   <= q_re_nxt[13:0];
                    q_im_q   <= q_im_nxt[13:0];
                    cnt      <= cnt - 4'd1;
                    if (cnt == 4'd0) begin
                        res_re      <= pick_result(dz_q, a_q, ovf_re_q, neg_re_q, q_re_nxt);
                        res_im      <= pick_result(dz_q, b_q, ovf_im_q, neg_im_q, q_im_nxt);
                        div_by_zero <= dz_q;
                        out_valid   <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_complex_div_iter.sv
// Directed testbench for complex_div_iter: hand-computed Q15 quotients,
// saturation, divide-by-zero, output back-pressure and mid-operation reset.
module tb_complex_div_iter;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x0_re;
    logic [15:0] x0_im;
    logic [15:0] x1_re;
    logic [15:0] x1_im;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] res_re;
    logic [15:0] res_im;
    logic        div_by_zero;

    int compared;
    int mismatched;

    complex_div_iter #(.DATA_WIDTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .x0_re       (x0_re),
        .x0_im       (x0_im),
        .x1_re       (x1_re),
        .x1_im       (x1_im),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .res_re      (res_re),
        .res_im      (res_im),
        .div_by_zero (div_by_zero)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one operand pair, let it be accepted on the next edge, then wait
    // (bounded) for out_valid and report how many edges that took.
    task automatic applyStimulus(input logic [15:0] ar, input logic [15:0] ai,
                                 input logic [15:0] cr, input logic [15:0] ci,
                                 output int lat);
        x0_re    = ar;
        x0_im    = ai;
        x1_re    = cr;
        x1_im    = ci;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Consume the current result and confirm the block is idle again.
    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput({tag, ".in_ready_back"}, 32'(in_ready), 32'd1);
        checkOutput({tag, ".out_valid_clr"}, 32'(out_valid), 32'd0);
    endtask

    task automatic runVector(input string tag,
                             input logic [15:0] ar, input logic [15:0] ai,
                             input logic [15:0] cr, input logic [15:0] ci,
                             input logic [15:0] exp_re, input logic [15:0] exp_im,
                             input logic exp_dz);
        int lat;
        applyStimulus(ar, ai, cr, ci, lat);
        checkOutput({tag, ".latency"}, 32'(lat), 32'd16);
        checkOutput({tag, ".re"}, 32'(res_re), 32'(exp_re));
        checkOutput({tag, ".im"}, 32'(res_im), 32'(exp_im));
        checkOutput({tag, ".dz"}, 32'(div_by_zero), 32'(exp_dz));
        consume(tag);
    endtask

    initial begin
        int lat;
        int stale;
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        x0_re      = '0;
        x0_im      = '0;
        x1_re      = '0;
        x1_im      = '0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset.res_re", 32'(res_re), 32'd0);
        checkOutput("reset.res_im", 32'(res_im), 32'd0);
        checkOutput("reset.dz", 32'(div_by_zero), 32'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("reset.in_ready", 32'(in_ready), 32'd1);

        // 0.25 / 0.5 = 0.5
        runVector("real_half", 16'd8192, 16'd0, 16'd16384, 16'd0, 16'h4000, 16'h0000, 1'b0);
        // 0.25 / 0.5j = -0.5j
        runVector("imag_den", 16'd8192, 16'd0, 16'd0, 16'd16384, 16'h0000, 16'hC000, 1'b0);
        // 1/3 truncates toward zero in both signs
        runVector("third_pos", 16'd1, 16'd0, 16'd3, 16'd0, 16'h2AAA, 16'h0000, 1'b0);
        runVector("third_neg", 16'hFFFF, 16'd0, 16'd3, 16'd0, 16'hD556, 16'h0000, 1'b0);
        // (0.5+0.25j)/(0.5+0.5j) = 0.75-0.25j
        runVector("complex", 16'd16384, 16'd8192, 16'd16384, 16'd16384, 16'h6000, 16'hE000, 1'b0);
        // Saturation
        runVector("sat_pos", 16'd16384, 16'd0, 16'd16384, 16'd0, 16'h7FFF, 16'h0000, 1'b0);
        runVector("sat_neg", 16'hC000, 16'd0, 16'd16384, 16'd0, 16'h8000, 16'h0000, 1'b0);
        runVector("sat_min", 16'h8000, 16'h8000, 16'd1, 16'd0, 16'h8000, 16'h8000, 1'b0);
        // Divide by zero
        runVector("dz_sign", 16'd100, 16'hFF9C, 16'd0, 16'd0, 16'h7FFF, 16'h8000, 1'b1);
        runVector("dz_zero", 16'd0, 16'd0, 16'd0, 16'd0, 16'h0000, 16'h0000, 1'b1);

        // Back-pressure: result held for 5 cycles while in_valid is pulsed.
        applyStimulus(16'd8192, 16'd0, 16'd16384, 16'd0, lat);
        checkOutput("hold.latency", 32'(lat), 32'd16);
        for (int i = 0; i < 5; i++) begin
            x0_re    = 16'd1;
            x1_re    = 16'd3;
            in_valid = (i % 2) == 0;
            @(posedge clk);
            #1;
            checkOutput($sformatf("hold%0d.out_valid", i), 32'(out_valid), 32'd1);
            checkOutput($sformatf("hold%0d.in_ready", i), 32'(in_ready), 32'd0);
            checkOutput($sformatf("hold%0d.re", i), 32'(res_re), 32'h4000);
            checkOutput($sformatf("hold%0d.im", i), 32'(res_im), 32'h0000);
        end
        in_valid = 1'b0;
        consume("hold");

        // Reset in the middle of the divide loop discards the operation.
        x0_re    = 16'd8192;
        x0_im    = 16'd0;
        x1_re    = 16'd0;
        x1_im    = 16'd16384;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("midreset.out_valid", 32'(out_valid), 32'd0);
        checkOutput("midreset.res_re", 32'(res_re), 32'd0);
        checkOutput("midreset.res_im", 32'(res_im), 32'd0);
        checkOutput("midreset.in_ready", 32'(in_ready), 32'd1);
        stale = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (out_valid) stale++;
        end
        checkOutput("midreset.no_stale", 32'(stale), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/complex_div_iter.md
Name: complex_div_iter

Overview:
- Sequential Q15 complex divider: res = x0 / x1 = (a+jb)/(c+jd).
- Inverse companion to the combinational complex multiply/add/sub primitives in the FFT datapath.
- Used for channel-equalisation and normalisation stages after the FFT.
- Valid/ready in, valid/ready out, one operation in flight, fixed latency, saturating Q15 output.

Parameters:
- DATA_WIDTH, 16, operand/result width. Only 16 (Q15) is supported; any other value is a config error.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block idle and able to accept; equals (state==IDLE).
- x0_re  input  16  numerator real part a, signed Q15.
- x0_im  input  16  numerator imag part b, signed Q15.
- x1_re  input  16  denominator real part c, signed Q15.
- x1_im  input  16  denominator imag part d, signed Q15.
- out_valid  output  1  result valid, held until consumed.
- out_ready  input  1  downstream accepts result.
- res_re  output  16  quotient real part, signed Q15, saturated.
- res_im  output  16  quotient imag part, signed Q15, saturated.
- div_by_zero  output  1  qualifies current result: denominator was 0+j0.

Behaviour:
- Reset (rst_n=0 at edge): state=IDLE, out_valid=0, res_re=res_im=0, div_by_zero=0, counter=0. Reset overrides any state, including mid-DIV or DONE; an in-flight op is discarded. in_ready=1 in the first cycle after reset is deasserted.
- FSM: IDLE -> MULT -> DIV -> DONE -> IDLE.
- IDLE: on in_valid&&in_ready at edge k, register all four operands and go to MULT.
- MULT (edge k+1):
  - num_re = ac+bd and num_im = bc-ad, each 33-bit signed Q30.
  - den = c*c+d*d, 32-bit unsigned Q30; max 2^31.
  - Store sign and 32-bit magnitude of each numerator.
  - ovf_x = (|num_x| >= den) per component.
  - dz = (den==0).
  - Load cnt=14; go to DIV.
- DIV (edges k+2..k+16):
  - Two parallel restoring dividers compute q_x = floor(|num_x|*2^15 / den), one quotient bit per cycle, MSB first, 15 iterations.
  - Since |num_x| < den when not ovf, q_x < 2^15.
  - Go to DONE when cnt==0.
- DONE entry (edge k+16): register outputs and set out_valid=1. Latency is 16 cycles from accept edge to out_valid.
- Result rule per component:
  - dz: +0x7FFF if num_x>0, 0x8000 if num_x<0, 0 if num_x==0 (num_x=0 when dz); div_by_zero=1.
  - ovf and sign positive: 0x7FFF.
  - ovf and sign negative: 0x8000.
  - Otherwise: +q_x or -q_x, so rounding is truncation toward zero.
  - Zero numerator gives 0 with no sign issue.
- DONE:
  - Hold res_*, div_by_zero and out_valid stable while out_ready=0.
  - On out_valid&&out_ready: out_valid=0 and go to IDLE; outputs keep last value.
  - No same-cycle re-accept: in_ready=0 in DONE. Throughput is one op per 18 cycles minimum.
- in_valid is ignored outside IDLE. Operand changes after accept have no effect.
- -32768 operands are legal: c*c=2^30. No intermediate overflow; all widths cover full range.

Test Plan:
- x0=8192+j0, x1=16384+j0 -> res_re=16384, res_im=0, div_by_zero=0; out_valid rises exactly 16 cycles after the accept edge.
- x0=8192+j0, x1=0+j16384 -> res_re=0, res_im=-16384 (0.25/0.5j = -0.5j).
- x0=1+j0, x1=3+j0 -> res_re=10922; x0=-1+j0, x1=3+j0 -> res_re=-10922 (truncation toward zero).
- Saturation:
  - x0=16384+j0, x1=16384+j0 -> res_re=32767, res_im=0.
  - x0=-16384+j0, x1=16384+j0 -> res_re=-32768.
  - x0=-32768-j32768, x1=1+j0 -> res_re=-32768, res_im=-32768.
- Divide by zero: x0=100-j100, x1=0+j0 -> res_re=0x7FFF, res_im=0x8000, div_by_zero=1; x0=0, x1=0 -> res=0, div_by_zero=1.
- Handshake/reset:
  - With out_ready=0 for 5 cycles in DONE, outputs stay stable, in_ready=0, and in_valid pulses are ignored.
  - On out_ready=1, in_ready returns 1 the next cycle.
  - rst_n=0 at DIV cycle 7 -> out_valid=0, res=0, in_ready=1 after release, and no stale result is emitted.
